// File: rtl/cpu_pkg.sv
// Shared types, default widths and helpers for the execute stage.
package cpu_pkg;

  localparam int N_DEF = 32;
  localparam int M_DEF = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  // Register-file write id meaning "no write": only bit m (the MSB of an
  // (m+1)-bit id) is set. Callers truncate to m+1 bits.
  function automatic logic [31:0] no_write_id(input int unsigned m);
    no_write_id = 32'd1 << m;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier datapath; exactly N steps per product,
// no early exit. The caller decides when to load and when to step.
module mul_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         step,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;

  // result is the accumulator after the current step, so on the final step
  // the caller can capture the finished product at the same edge.
  assign result = mplier[0] ? (acc + mcand) : acc;
  assign done   = step && (cnt == CW'(N - 1));

  // Load operands on start, otherwise advance one shift-add iteration per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= result;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops written straight to the register file
// write port, plus a multi-cycle multiply run through mul_seq.
module exec_unit
  import cpu_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_e          op,
  input  logic [M-1:0] rd,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [M:0]   w1,
  output logic [N-1:0] w,
  output logic         busy
);

  typedef enum logic {ST_IDLE, ST_MUL} state_e;

  localparam logic [M:0] NO_WRITE = (M + 1)'(no_write_id(M));

  state_e       state;
  state_e       next_state;
  logic         accept;
  logic         mul_start;
  logic         mul_step;
  logic         mul_done;
  logic [N-1:0] mul_result;
  logic [N-1:0] alu_result;
  logic [M-1:0] rd_lat;

  assign accept = in_valid && in_ready;

  mul_seq #(.N(N)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .step   (mul_step),
    .a      (a),
    .b      (b),
    .done   (mul_done),
    .result (mul_result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Next state and handshake: ready only in IDLE, MUL iterates until done.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (accept && op == OP_MUL) begin
          mul_start  = 1'b1;
          next_state = ST_MUL;
        end
      end
      ST_MUL: begin
        busy     = 1'b1;
        mul_step = 1'b1;
        if (mul_done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Single-cycle ALU; the MUL code is handled by mul_seq, not here.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = a + b;
      OP_SUB:  alu_result = a - b;
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_XOR:  alu_result = a ^ b;
      OP_SLT:  alu_result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASS: alu_result = b;
      default: alu_result = '0;
    endcase
  end

  // Write-port registers: one write pulse per completed op, w holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w1     <= NO_WRITE;
      w      <= '0;
      rd_lat <= '0;
    end else begin
      w1 <= NO_WRITE;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              rd_lat <= rd;
            end else begin
              w1 <= {1'b0, rd};
              w  <= alu_result;
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            w1 <= {1'b0, rd_lat};
            w  <= mul_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
